result_wb_writer: RTL and testbench

Parametrised result write-back sequencer. It captures one DATA_W-bit result (e.g. an AES block) on a start request and writes it to data memory as DATA_W/WORD_W consecutive words at a runtime base address. It honours a memory-ready stall, supports selectable word order, and reports completion with a ready/busy/done handshake. It sits between the crypto/accelerator result path and the data-memory write port, as the generalised successor of the fixed 4-word write-back path.

---
 rtl/result_wb_writer_if.sv | 24 ++
 rtl/result_wb_writer.sv | 105 ++++++++++
 tb/tb_result_wb_writer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_wb_writer_if.sv
// Data-memory write port bundle: one word per accepted write, with ready-based stall.
interface result_wb_writer_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_ready;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ready
  );

  modport slave (
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready
  );
endinterface

// File: rtl/result_wb_writer.sv
// Result write-back sequencer: captures a DATA_W-bit result on start and writes
// it to data memory as DATA_W/WORD_W words at ascending addresses from a base.
module result_wb_writer #(
  parameter int DATA_W      = 128,
  parameter int WORD_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int ADDR_STRIDE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_W-1:0]    result_in,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic                 msw_first,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  result_wb_writer_if.master   mem
);
  localparam int N_WORDS = DATA_W / WORD_W;
  localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] data_q;
  logic              msw_q;
  logic [IDX_W-1:0]  idx;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              done_q;
  logic              last_word;

  // Word k of a result in the requested order; k counts issue order, not bit position.
  function automatic logic [WORD_W-1:0] pick_word(input logic [DATA_W-1:0] d,
                                                  input logic msw,
                                                  input int k);
    int sh;
    sh = msw ? (N_WORDS - 1 - k) * WORD_W : k * WORD_W;
    return WORD_W'(d >> sh);
  endfunction

  assign last_word     = (idx == IDX_W'(N_WORDS - 1));
  assign ready         = (state == S_IDLE);
  assign busy          = (state == S_WRITE);
  assign done          = done_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  // Sequencer: capture on start, advance one word per accepted write, pulse done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      data_q  <= '0;
      msw_q   <= 1'b0;
      idx     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state   <= S_WRITE;
            data_q  <= result_in;
            msw_q   <= msw_first;
            idx     <= '0;
            we_q    <= 1'b1;
            addr_q  <= base_addr;
            wdata_q <= pick_word(result_in, msw_first, 0);
          end
        end
        S_WRITE: begin
          // Outputs hold while memory stalls; the address register is the running address.
          if (mem.mem_ready) begin
            if (last_word) begin
              state  <= S_DONE;
              we_q   <= 1'b0;
              done_q <= 1'b1;
            end else begin
              idx     <= idx + IDX_W'(1);
              addr_q  <= addr_q + ADDR_W'(ADDR_STRIDE);
              wdata_q <= pick_word(data_q, msw_q, int'(idx) + 1);
            end
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          we_q   <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_result_wb_writer.sv
// Bench for result_wb_writer: three instances (128/32, 64/16 stride 2, 32/32)
// checked cycle by cycle against an order/address model built from the result value.
module tb_result_wb_writer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   checks = 0;
  int   errors = 0;

  // Instance A: DATA_W=128, WORD_W=32, stride 4
  logic         a_start, a_msw, a_ready, a_busy, a_done;
  logic [127:0] a_res;
  logic [31:0]  a_base;
  result_wb_writer_if #(.ADDR_W(32), .WORD_W(32)) a_mem ();
  result_wb_writer #(.DATA_W(128), .WORD_W(32), .ADDR_W(32), .ADDR_STRIDE(4)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .result_in(a_res), .base_addr(a_base),
    .msw_first(a_msw), .ready(a_ready), .busy(a_busy), .done(a_done), .mem(a_mem)
  );

  // Instance B: DATA_W=64, WORD_W=16, stride 2
  logic         b_start, b_msw, b_ready, b_busy, b_done;
  logic [63:0]  b_res;
  logic [31:0]  b_base;
  result_wb_writer_if #(.ADDR_W(32), .WORD_W(16)) b_mem ();
  result_wb_writer #(.DATA_W(64), .WORD_W(16), .ADDR_W(32), .ADDR_STRIDE(2)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .result_in(b_res), .base_addr(b_base),
    .msw_first(b_msw), .ready(b_ready), .busy(b_busy), .done(b_done), .mem(b_mem)
  );

  // Instance C: DATA_W=WORD_W=32, single-word burst
  logic         c_start, c_msw, c_ready, c_busy, c_done;
  logic [31:0]  c_res;
  logic [31:0]  c_base;
  result_wb_writer_if #(.ADDR_W(32), .WORD_W(32)) c_mem ();
  result_wb_writer #(.DATA_W(32), .WORD_W(32), .ADDR_W(32), .ADDR_STRIDE(4)) dut_c (
    .clk(clk), .reset(reset), .start(c_start), .result_in(c_res), .base_addr(c_base),
    .msw_first(c_msw), .ready(c_ready), .busy(c_busy), .done(c_done), .mem(c_mem)
  );

  logic [31:0] exp_addr [4];
  logic [31:0] exp_data [4];

  // Reference: slice the result into words LSW-first, reverse for MSW-first, addresses ascend.
  task automatic model_a(input logic [127:0] r, input logic [31:0] b, input logic msw);
    logic [31:0]  words[$];
    logic [127:0] t;
    t = r;
    words.delete();
    for (int i = 0; i < 4; i++) begin
      words.push_back(t[31:0]);
      t = t >> 32;
    end
    for (int i = 0; i < 4; i++) begin
      exp_data[i] = msw ? words[3 - i] : words[i];
      exp_addr[i] = b + 32'(4 * i);
    end
  endtask

  // One burst on A with s[k] stall cycles before word k; noise keeps start high with fresh inputs.
  task automatic run_a(input string name, input logic [127:0] r, input logic [31:0] b,
                       input logic msw, input int s0, input int s1, input int s2,
                       input int s3, input bit noise);
    int stalls[4];
    int k, left, cyc;
    stalls[0] = s0; stalls[1] = s1; stalls[2] = s2; stalls[3] = s3;
    model_a(r, b, msw);
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_start: got %b want 1", name, a_ready);
    end
    a_start = 1'b1; a_res = r; a_base = b; a_msw = msw; a_mem.mem_ready = 1'b1;
    @(negedge clk);
    k = 0; left = stalls[0]; cyc = 0;
    while (k < 4 && cyc < 60) begin
      if (!noise) a_start = 1'b0;
      a_res  = {$urandom, $urandom, $urandom, $urandom};
      a_base = $urandom;
      a_msw  = 1'($urandom_range(0, 1));
      checks++;
      if (a_mem.mem_we !== 1'b1 || a_mem.mem_addr !== exp_addr[k] ||
          a_mem.mem_wdata !== exp_data[k] || a_busy !== 1'b1 || a_ready !== 1'b0 ||
          a_done !== 1'b0) begin
        errors++;
        $display("FAIL %s word%0d cyc%0d: got we=%b addr=%h data=%h busy=%b ready=%b done=%b want we=1 addr=%h data=%h busy=1 ready=0 done=0",
                 name, k, cyc, a_mem.mem_we, a_mem.mem_addr, a_mem.mem_wdata, a_busy,
                 a_ready, a_done, exp_addr[k], exp_data[k]);
      end
      if (left > 0) begin
        a_mem.mem_ready = 1'b0;
        left--;
      end else begin
        a_mem.mem_ready = 1'b1;
        k++;
        if (k < 4) left = stalls[k];
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 60) begin
      checks++; errors++;
      $display("FAIL %s timeout: got %0d cycles want %0d", name, cyc, 4 + s0 + s1 + s2 + s3);
    end
    a_mem.mem_ready = 1'($urandom_range(0, 1));
    checks++;
    if (a_done !== 1'b1 || a_mem.mem_we !== 1'b0 || a_busy !== 1'b0 || a_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s done_cycle: got done=%b we=%b busy=%b ready=%b want 1 0 0 0",
               name, a_done, a_mem.mem_we, a_busy, a_ready);
    end
    @(negedge clk);
    a_start = 1'b0;
    checks++;
    if (a_done !== 1'b0 || a_ready !== 1'b1 || a_mem.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got done=%b ready=%b we=%b want 0 1 0",
               name, a_done, a_ready, a_mem.mem_we);
    end
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || a_mem.mem_we !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s no_queued_start: got ready=%b we=%b busy=%b want 1 0 0",
               name, a_ready, a_mem.mem_we, a_busy);
    end
    a_mem.mem_ready = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (a_mem.mem_we !== 1'b0 || a_mem.mem_addr !== 32'h0 || a_mem.mem_wdata !== 32'h0 ||
        a_done !== 1'b0 || a_busy !== 1'b0 || a_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_a: got we=%b addr=%h data=%h done=%b busy=%b ready=%b want 0 0 0 0 0 1",
               a_mem.mem_we, a_mem.mem_addr, a_mem.mem_wdata, a_done, a_busy, a_ready);
    end
    checks++;
    if (b_ready !== 1'b1 || b_mem.mem_we !== 1'b0 || c_ready !== 1'b1 || c_mem.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_bc: got b_ready=%b b_we=%b c_ready=%b c_we=%b want 1 0 1 0",
               b_ready, b_mem.mem_we, c_ready, c_mem.mem_we);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_msw;
    run_a("basic_msw", 128'h00112233_44556677_8899AABB_CCDDEEFF, 32'd500, 1'b1, 0, 0, 0, 0, 1'b0);
    checks++;
    if (exp_data[0] !== 32'h00112233 || exp_addr[3] !== 32'd512) begin
      errors++;
      $display("FAIL basic_msw_model: got first=%h last_addr=%0d want 00112233 512",
               exp_data[0], exp_addr[3]);
    end
  endtask

  task automatic test_lsw_stall;
    run_a("lsw_stall", 128'h00112233_44556677_8899AABB_CCDDEEFF, 32'd500, 1'b0, 0, 2, 0, 0, 1'b0);
  endtask

  task automatic test_addr_wrap;
    run_a("addr_wrap", {$urandom, $urandom, $urandom, $urandom}, 32'hFFFF_FFF8, 1'b1, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_start_during_burst;
    run_a("start_in_burst", {$urandom, $urandom, $urandom, $urandom}, $urandom, 1'b1, 1, 0, 1, 0, 1'b1);
    run_a("start_in_burst_lsw", {$urandom, $urandom, $urandom, $urandom}, $urandom, 1'b0, 0, 0, 0, 0, 1'b1);
  endtask

  task automatic test_reset_mid_burst;
    @(negedge clk);
    a_start = 1'b1; a_res = {$urandom, $urandom, $urandom, $urandom}; a_base = 32'd64; a_msw = 1'b1;
    a_mem.mem_ready = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (a_mem.mem_we !== 1'b1 || a_mem.mem_addr !== 32'd72) begin
      errors++;
      $display("FAIL mid_burst_word2: got we=%b addr=%0d want 1 72", a_mem.mem_we, a_mem.mem_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (a_mem.mem_we !== 1'b0 || a_mem.mem_addr !== 32'h0 || a_mem.mem_wdata !== 32'h0 ||
        a_ready !== 1'b1 || a_busy !== 1'b0 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_burst: got we=%b addr=%h data=%h ready=%b busy=%b done=%b want 0 0 0 1 0 0",
               a_mem.mem_we, a_mem.mem_addr, a_mem.mem_wdata, a_ready, a_busy, a_done);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (a_done !== 1'b0 || a_mem.mem_we !== 1'b0) begin
        errors++;
        $display("FAIL aborted_burst_quiet cyc%0d: got done=%b we=%b want 0 0", i, a_done, a_mem.mem_we);
      end
    end
    run_a("after_reset", {$urandom, $urandom, $urandom, $urandom}, $urandom, 1'b0, 0, 1, 0, 0, 1'b0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 8; n++) begin
      run_a("random", {$urandom, $urandom, $urandom, $urandom}, $urandom,
            1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2),
            $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_param_b;
    logic [63:0] r, t;
    logic        msw;
    logic [15:0] w[$];
    logic [15:0] ed[4];
    int k, cyc;
    r = {$urandom, $urandom};
    msw = 1'($urandom_range(0, 1));
    t = r;
    w.delete();
    for (int i = 0; i < 4; i++) begin
      w.push_back(t[15:0]);
      t = t >> 16;
    end
    for (int i = 0; i < 4; i++) ed[i] = msw ? w[3 - i] : w[i];
    @(negedge clk);
    b_start = 1'b1; b_res = r; b_base = 32'h100; b_msw = msw; b_mem.mem_ready = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    k = 0; cyc = 0;
    while (k < 4 && cyc < 40) begin
      checks++;
      if (b_mem.mem_we !== 1'b1 || b_mem.mem_addr !== 32'h100 + 32'(2 * k) || b_mem.mem_wdata !== ed[k]) begin
        errors++;
        $display("FAIL param_b word%0d: got we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                 k, b_mem.mem_we, b_mem.mem_addr, b_mem.mem_wdata, 32'h100 + 32'(2 * k), ed[k]);
      end
      b_mem.mem_ready = 1'($urandom_range(0, 1));
      if (b_mem.mem_ready) k++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 40 || b_done !== 1'b1 || b_mem.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL param_b done: got done=%b we=%b cyc=%0d want 1 0", b_done, b_mem.mem_we, cyc);
    end
    @(negedge clk);
    checks++;
    if (b_ready !== 1'b1 || b_done !== 1'b0) begin
      errors++;
      $display("FAIL param_b idle: got ready=%b done=%b want 1 0", b_ready, b_done);
    end
    b_mem.mem_ready = 1'b1;
  endtask

  task automatic test_param_c;
    logic [31:0] r, b;
    r = $urandom; b = $urandom;
    @(negedge clk);
    c_start = 1'b1; c_res = r; c_base = b; c_msw = 1'($urandom_range(0, 1)); c_mem.mem_ready = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    checks++;
    if (c_mem.mem_we !== 1'b1 || c_mem.mem_addr !== b || c_mem.mem_wdata !== r || c_busy !== 1'b1) begin
      errors++;
      $display("FAIL param_c write: got we=%b addr=%h data=%h busy=%b want 1 %h %h 1",
               c_mem.mem_we, c_mem.mem_addr, c_mem.mem_wdata, c_busy, b, r);
    end
    @(negedge clk);
    checks++;
    if (c_done !== 1'b1 || c_mem.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL param_c done: got done=%b we=%b want 1 0", c_done, c_mem.mem_we);
    end
    @(negedge clk);
    checks++;
    if (c_ready !== 1'b1 || c_done !== 1'b0 || c_mem.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL param_c idle: got ready=%b done=%b we=%b want 1 0 0", c_ready, c_done, c_mem.mem_we);
    end
  endtask

  initial begin
    reset = 1'b1;
    a_start = 1'b0; a_res = '0; a_base = '0; a_msw = 1'b0; a_mem.mem_ready = 1'b1;
    b_start = 1'b0; b_res = '0; b_base = '0; b_msw = 1'b0; b_mem.mem_ready = 1'b1;
    c_start = 1'b0; c_res = '0; c_base = '0; c_msw = 1'b0; c_mem.mem_ready = 1'b1;
    test_reset();
    test_basic_msw();
    test_lsw_stall();
    test_addr_wrap();
    test_start_during_burst();
    test_reset_mid_burst();
    test_random();
    test_param_b();
    test_param_c();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
